// File: rtl/ctrl_pkg.sv
// Shared definitions for the multicycle MIPS controller: states, opcodes,
// funct codes, ALU control codes and the internal ALU operation class.
package ctrl_pkg;

    localparam int OP_W      = 6;
    localparam int FN_W      = 6;
    localparam int ALU_CTL_W = 3;

    // One state per instruction step; 4-bit encoding.
    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    // Supported opcodes.
    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;

    // R-type funct codes understood by the ALU decoder.
    localparam logic [FN_W-1:0] FN_ADD = 6'b100000;
    localparam logic [FN_W-1:0] FN_SUB = 6'b100010;
    localparam logic [FN_W-1:0] FN_AND = 6'b100100;
    localparam logic [FN_W-1:0] FN_OR  = 6'b100101;
    localparam logic [FN_W-1:0] FN_SLT = 6'b101010;

    // ALU control codes driven to the datapath.
    localparam logic [ALU_CTL_W-1:0] ALU_AND = 3'b000;
    localparam logic [ALU_CTL_W-1:0] ALU_OR  = 3'b001;
    localparam logic [ALU_CTL_W-1:0] ALU_ADD = 3'b010;
    localparam logic [ALU_CTL_W-1:0] ALU_SUB = 3'b110;
    localparam logic [ALU_CTL_W-1:0] ALU_SLT = 3'b111;

    // Operation class requested by the main FSM.
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'd0,
        ALUOP_SUB   = 2'd1,
        ALUOP_FUNCT = 2'd2
    } alu_op_t;

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU decoder: operation class plus funct -> ALU control code.
// Kept separate so a single-cycle controller can reuse it unchanged.
module alu_decoder
    import ctrl_pkg::*;
#(
    parameter int fnW     = 6,
    parameter int aluCtlW = 3
) (
    input  alu_op_t            aluOp,
    input  logic [fnW-1:0]     funct,
    output logic [aluCtlW-1:0] aluControl
);

    // Map the operation class (and funct for R-type) onto an ALU control code.
    always_comb begin
        aluControl = ALU_ADD;
        case (aluOp)
            ALUOP_ADD: aluControl = ALU_ADD;
            ALUOP_SUB: aluControl = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_ADD:  aluControl = ALU_ADD;
                    FN_SUB:  aluControl = ALU_SUB;
                    FN_AND:  aluControl = ALU_AND;
                    FN_OR:   aluControl = ALU_OR;
                    FN_SLT:  aluControl = ALU_SLT;
                    // Unknown funct behaves as add; writeback still happens.
                    default: aluControl = ALU_ADD;
                endcase
            end
            default: aluControl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/control_fsm.sv
// Multicycle MIPS main controller: Moore FSM that sequences every datapath
// select and enable, one state per instruction step.
module control_fsm
    import ctrl_pkg::*;
#(
    parameter int opW     = 6,
    parameter int fnW     = 6,
    parameter int aluCtlW = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [opW-1:0]     opcode,
    input  logic [fnW-1:0]     funct,
    input  logic               zero,
    output logic               dffEnable,
    output logic               irWrite,
    output logic               iOrD,
    output logic               memWrite,
    output logic               memToReg,
    output logic               regDst,
    output logic               writeEnable,
    output logic               aluSrcA,
    output logic [1:0]         aluSrcB,
    output logic [aluCtlW-1:0] aluControl,
    output logic               pcSrc,
    output logic               jump,
    output logic               instrDone,
    output logic               illegalOp
);

    state_t               state;
    state_t               next_state;
    alu_op_t              alu_op;
    logic                 alu_active;
    logic [aluCtlW-1:0]   alu_code;
    logic                 pc_write;
    logic                 branch;
    logic                 ir_write_raw;
    logic                 mem_write_raw;
    logic                 write_enable_raw;
    logic                 instr_done_raw;
    logic                 illegal_raw;
    logic                 legal_op;

    alu_decoder #(
        .fnW     (fnW),
        .aluCtlW (aluCtlW)
    ) u_alu_decoder (
        .aluOp      (alu_op),
        .funct      (funct),
        .aluControl (alu_code)
    );

    // Opcode recognised by DECODE; anything else is reported as illegal.
    assign legal_op = (opcode == OP_RTYPE) || (opcode == OP_LW) ||
                      (opcode == OP_SW)    || (opcode == OP_BEQ) ||
                      (opcode == OP_ADDI)  || (opcode == OP_J);

    // State register; reset aborts any instruction and returns to FETCH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: opcode only matters in DECODE and MEMADR.
    always_comb begin
        next_state = S_FETCH;
        case (state)
            S_FETCH: next_state = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW:    next_state = S_MEMADR;
                    OP_SW:    next_state = S_MEMADR;
                    OP_RTYPE: next_state = S_EXECUTE;
                    OP_BEQ:   next_state = S_BRANCH;
                    OP_ADDI:  next_state = S_ADDIEX;
                    OP_J:     next_state = S_JUMP;
                    default:  next_state = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                if (opcode == OP_SW) begin
                    next_state = S_MEMWR;
                end else begin
                    next_state = S_MEMRD;
                end
            end
            S_MEMRD:   next_state = S_MEMWB;
            S_EXECUTE: next_state = S_ALUWB;
            S_ADDIEX:  next_state = S_ADDIWB;
            default:   next_state = S_FETCH;
        endcase
    end

    // Moore output decode; architectural strobes are held low during reset.
    always_comb begin
        pc_write         = 1'b0;
        branch           = 1'b0;
        ir_write_raw     = 1'b0;
        mem_write_raw    = 1'b0;
        write_enable_raw = 1'b0;
        instr_done_raw   = 1'b0;
        illegal_raw      = 1'b0;
        iOrD             = 1'b0;
        memToReg         = 1'b0;
        regDst           = 1'b0;
        aluSrcA          = 1'b0;
        aluSrcB          = 2'b00;
        pcSrc            = 1'b0;
        jump             = 1'b0;
        alu_op           = ALUOP_ADD;
        alu_active       = 1'b0;
        case (state)
            S_FETCH: begin
                aluSrcB      = 2'b01;
                alu_active   = 1'b1;
                ir_write_raw = 1'b1;
                pc_write     = 1'b1;
            end
            S_DECODE: begin
                aluSrcB    = 2'b11;
                alu_active = 1'b1;
                if (!legal_op) begin
                    illegal_raw    = 1'b1;
                    instr_done_raw = 1'b1;
                end else begin
                    illegal_raw    = 1'b0;
                    instr_done_raw = 1'b0;
                end
            end
            S_MEMADR: begin
                aluSrcA    = 1'b1;
                aluSrcB    = 2'b10;
                alu_active = 1'b1;
            end
            S_MEMRD: begin
                iOrD = 1'b1;
            end
            S_MEMWB: begin
                memToReg         = 1'b1;
                write_enable_raw = 1'b1;
                instr_done_raw   = 1'b1;
            end
            S_MEMWR: begin
                iOrD           = 1'b1;
                mem_write_raw  = 1'b1;
                instr_done_raw = 1'b1;
            end
            S_EXECUTE: begin
                aluSrcA    = 1'b1;
                alu_op     = ALUOP_FUNCT;
                alu_active = 1'b1;
            end
            S_ALUWB: begin
                regDst           = 1'b1;
                write_enable_raw = 1'b1;
                instr_done_raw   = 1'b1;
            end
            S_BRANCH: begin
                aluSrcA        = 1'b1;
                alu_op         = ALUOP_SUB;
                alu_active     = 1'b1;
                pcSrc          = 1'b1;
                branch         = 1'b1;
                instr_done_raw = 1'b1;
            end
            S_ADDIEX: begin
                aluSrcA    = 1'b1;
                aluSrcB    = 2'b10;
                alu_active = 1'b1;
            end
            S_ADDIWB: begin
                write_enable_raw = 1'b1;
                instr_done_raw   = 1'b1;
            end
            S_JUMP: begin
                jump           = 1'b1;
                pc_write       = 1'b1;
                instr_done_raw = 1'b1;
            end
            default: begin
                pc_write = 1'b0;
            end
        endcase
    end

    // ALU control is only meaningful in states that use the ALU; zero elsewhere.
    assign aluControl  = alu_active ? alu_code : {aluCtlW{1'b0}};
    assign dffEnable   = ~reset & (pc_write | (branch & zero));
    assign irWrite     = ~reset & ir_write_raw;
    assign memWrite    = ~reset & mem_write_raw;
    assign writeEnable = ~reset & write_enable_raw;
    assign instrDone   = ~reset & instr_done_raw;
    assign illegalOp   = ~reset & illegal_raw;

endmodule

// File: tb/tb_control_fsm.sv
// Directed bench for control_fsm: walks each instruction class state by state
// and compares the full output vector against hand-derived constants.
module tb_control_fsm;

    logic       clk;
    logic       reset;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       dffEnable, irWrite, iOrD, memWrite, memToReg, regDst;
    logic       writeEnable, aluSrcA, pcSrc, jump, instrDone, illegalOp;
    logic [1:0] aluSrcB;
    logic [2:0] aluControl;

    int tests;
    int fails;

    control_fsm #(.opW(6), .fnW(6), .aluCtlW(3)) dut (
        .clk         (clk),
        .reset       (reset),
        .opcode      (opcode),
        .funct       (funct),
        .zero        (zero),
        .dffEnable   (dffEnable),
        .irWrite     (irWrite),
        .iOrD        (iOrD),
        .memWrite    (memWrite),
        .memToReg    (memToReg),
        .regDst      (regDst),
        .writeEnable (writeEnable),
        .aluSrcA     (aluSrcA),
        .aluSrcB     (aluSrcB),
        .aluControl  (aluControl),
        .pcSrc       (pcSrc),
        .jump        (jump),
        .instrDone   (instrDone),
        .illegalOp   (illegalOp)
    );

    // Vector layout: dffEn irW iOrD memW m2r regDst we srcA srcB[2] alu[3] pcSrc jump done ill
    logic [16:0] obs;
    assign obs = {dffEnable, irWrite, iOrD, memWrite, memToReg, regDst, writeEnable,
                  aluSrcA, aluSrcB, aluControl, pcSrc, jump, instrDone, illegalOp};

    localparam logic [16:0] E_RST     = {7'b0000000, 1'b0, 2'b01, 3'b010, 4'b0000};
    localparam logic [16:0] E_FETCH   = {7'b1100000, 1'b0, 2'b01, 3'b010, 4'b0000};
    localparam logic [16:0] E_DECODE  = {7'b0000000, 1'b0, 2'b11, 3'b010, 4'b0000};
    localparam logic [16:0] E_DEC_ILL = {7'b0000000, 1'b0, 2'b11, 3'b010, 4'b0011};
    localparam logic [16:0] E_MEMADR  = {7'b0000000, 1'b1, 2'b10, 3'b010, 4'b0000};
    localparam logic [16:0] E_MEMRD   = {7'b0010000, 1'b0, 2'b00, 3'b000, 4'b0000};
    localparam logic [16:0] E_MEMWB   = {7'b0000101, 1'b0, 2'b00, 3'b000, 4'b0010};
    localparam logic [16:0] E_MEMWR   = {7'b0011000, 1'b0, 2'b00, 3'b000, 4'b0010};
    localparam logic [16:0] E_EX_SLT  = {7'b0000000, 1'b1, 2'b00, 3'b111, 4'b0000};
    localparam logic [16:0] E_EX_AND  = {7'b0000000, 1'b1, 2'b00, 3'b000, 4'b0000};
    localparam logic [16:0] E_EX_UNK  = {7'b0000000, 1'b1, 2'b00, 3'b010, 4'b0000};
    localparam logic [16:0] E_ALUWB   = {7'b0000011, 1'b0, 2'b00, 3'b000, 4'b0010};
    localparam logic [16:0] E_BR_Z1   = {7'b1000000, 1'b1, 2'b00, 3'b110, 4'b1010};
    localparam logic [16:0] E_BR_Z0   = {7'b0000000, 1'b1, 2'b00, 3'b110, 4'b1010};
    localparam logic [16:0] E_ADDIEX  = {7'b0000000, 1'b1, 2'b10, 3'b010, 4'b0000};
    localparam logic [16:0] E_ADDIWB  = {7'b0000001, 1'b0, 2'b00, 3'b000, 4'b0010};
    localparam logic [16:0] E_JUMP    = {7'b1000000, 1'b0, 2'b00, 3'b000, 4'b0110};

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sample 1 time unit after the falling edge, compare, then move to the next falling edge.
    task automatic st(input string tag, input logic [16:0] exp);
        #1;
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%05h expected=%05h", tag, obs, exp);
        end
        @(negedge clk);
    endtask

    initial begin
        tests  = 0;
        fails  = 0;
        reset  = 1'b1;
        opcode = 6'b000000;
        funct  = 6'b000000;
        zero   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        st("reset_hold", E_RST);

        // lw, full 5-cycle flow.
        reset = 1'b0; opcode = 6'b100011;
        st("lw_fetch", E_FETCH);
        st("lw_decode", E_DECODE);
        st("lw_memadr", E_MEMADR);
        st("lw_memrd", E_MEMRD);
        st("lw_memwb", E_MEMWB);

        // lw aborted by reset during MEMRD.
        st("lw2_fetch", E_FETCH);
        st("lw2_decode", E_DECODE);
        st("lw2_memadr", E_MEMADR);
        reset = 1'b1;
        st("abort_rst", E_RST);
        st("abort_rst_hold", E_RST);
        reset = 1'b0; opcode = 6'b101011;
        st("abort_refetch", E_FETCH);

        // sw continues from the refetch.
        st("sw_decode", E_DECODE);
        st("sw_memadr", E_MEMADR);
        st("sw_memwr", E_MEMWR);

        // R-type slt.
        opcode = 6'b000000; funct = 6'b101010;
        st("slt_fetch", E_FETCH);
        st("slt_decode", E_DECODE);
        st("slt_execute", E_EX_SLT);
        st("slt_aluwb", E_ALUWB);

        // R-type and.
        funct = 6'b100100;
        st("and_fetch", E_FETCH);
        st("and_decode", E_DECODE);
        st("and_execute", E_EX_AND);
        st("and_aluwb", E_ALUWB);

        // R-type unknown funct falls back to add and still writes back.
        funct = 6'b111111;
        st("unk_fetch", E_FETCH);
        st("unk_decode", E_DECODE);
        st("unk_execute", E_EX_UNK);
        st("unk_aluwb", E_ALUWB);

        // beq taken.
        opcode = 6'b000100; zero = 1'b1;
        st("beq1_fetch", E_FETCH);
        st("beq1_decode", E_DECODE);
        st("beq1_branch", E_BR_Z1);

        // beq not taken.
        zero = 1'b0;
        st("beq0_fetch", E_FETCH);
        st("beq0_decode", E_DECODE);
        st("beq0_branch", E_BR_Z0);

        // addi with zero high to confirm it does not leak into dffEnable.
        opcode = 6'b001000; zero = 1'b1;
        st("addi_fetch", E_FETCH);
        st("addi_decode", E_DECODE);
        st("addi_ex", E_ADDIEX);
        st("addi_wb", E_ADDIWB);

        // j.
        opcode = 6'b000010; zero = 1'b0;
        st("j_fetch", E_FETCH);
        st("j_decode", E_DECODE);
        st("j_jump", E_JUMP);

        // Illegal opcode returns straight to FETCH.
        opcode = 6'b111111;
        st("ill_fetch", E_FETCH);
        st("ill_decode", E_DEC_ILL);
        opcode = 6'b000010;
        st("ill_next_fetch", E_FETCH);
        st("ill_next_decode", E_DECODE);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/control_fsm.md
Name: control_fsm

Overview:
- Multicycle MIPS main controller. It is the control end of the processor's datapath interface.
- Consumes opcode/funct from the instruction register plus the ALU zero flag.
- Drives every datapath select and enable (PC enable, mux selects, register write, ALU control, memory strobes) as a Moore FSM, one state per instruction step.
- Sits beside datapath at the processor top level. It has no datapath arithmetic of its own.

Parameters:
- opW, 6, opcode width (instruction[31:26])
- fnW, 6, funct width (instruction[5:0])
- aluCtlW, 3, aluControl width

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- opcode  input  opW  instruction[31:26] from the instruction register
- funct  input  fnW  instruction[5:0]
- zero  input  1  ALU zero flag from datapath
- dffEnable  output  1  PC register enable
- irWrite  output  1  instruction register load
- iOrD  output  1  memory address select: 0 = PC, 1 = ALUOut
- memWrite  output  1  data memory write strobe
- memToReg  output  1  writeback select: 1 = memory data
- regDst  output  1  destination register select: 1 = rd, 0 = rt
- writeEnable  output  1  register file write
- aluSrcA  output  1  ALU operand A: 0 = PC, 1 = regA
- aluSrcB  output  2  ALU operand B: 00 = regB, 01 = const 4, 10 = signImm, 11 = signImmSh
- aluControl  output  aluCtlW  ALU operation
- pcSrc  output  1  next-PC select: 0 = ALU result, 1 = ALUOut (branch target)
- jump  output  1  next-PC select: jump target
- instrDone  output  1  one-cycle pulse in the final state of each instruction
- illegalOp  output  1  one-cycle pulse in DECODE when the opcode is unsupported

Behaviour:
- Fixed: one clock; reset asynchronous, active-high. Reset forces state = FETCH.
- While reset is high, irWrite, dffEnable, memWrite, writeEnable, instrDone and illegalOp are forced to 0. All other outputs are Moore-decoded from state.
- Any output not listed for a state is 0 in that state.
- Opcodes: R = 000000, lw = 100011, sw = 101011, beq = 000100, addi = 001000, j = 000010.
- State list, with asserted outputs and next state:
  - FETCH: iOrD=0, aluSrcA=0, aluSrcB=01, aluOp=add, irWrite=1, pcWrite=1. Next: DECODE.
  - DECODE: aluSrcA=0, aluSrcB=11, aluOp=add.
    - Next by opcode: lw/sw -> MEMADR; R -> EXECUTE; beq -> BRANCH; addi -> ADDIEX; j -> JUMP.
    - Any other opcode -> FETCH, with illegalOp=1 and instrDone=1. No architectural write occurs.
  - MEMADR: aluSrcA=1, aluSrcB=10, aluOp=add. Next: MEMRD for lw, MEMWR for sw.
  - MEMRD: iOrD=1. Next: MEMWB.
  - MEMWB: regDst=0, memToReg=1, writeEnable=1, instrDone=1. Next: FETCH.
  - MEMWR: iOrD=1, memWrite=1, instrDone=1. Next: FETCH.
  - EXECUTE: aluSrcA=1, aluSrcB=00, aluOp=funct. Next: ALUWB.
  - ALUWB: regDst=1, memToReg=0, writeEnable=1, instrDone=1. Next: FETCH.
  - BRANCH: aluSrcA=1, aluSrcB=00, aluOp=sub, pcSrc=1, branch=1, instrDone=1. Next: FETCH.
  - ADDIEX: aluSrcA=1, aluSrcB=10, aluOp=add. Next: ADDIWB.
  - ADDIWB: regDst=0, memToReg=0, writeEnable=1, instrDone=1. Next: FETCH.
  - JUMP: jump=1, pcWrite=1, instrDone=1. Next: FETCH.
- dffEnable = pcWrite | (branch & zero). zero is sampled combinationally in BRANCH only.
- Latency in cycles, FETCH through last state: lw 5, sw 4, R 4, addi 4, beq 3, j 3, illegal 2.
- ALU decode:
  - aluOp add -> 010; sub -> 110.
  - aluOp funct: 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111.
  - Unknown funct -> 010. Writeback still occurs; this is defined behaviour.
- opcode/funct are used only in DECODE and in the MEMADR branch decision. They are held stable by the instruction register after FETCH.
- Reset asserted mid-instruction aborts it immediately: no further writes, resume at FETCH after reset deasserts.

Decomposition:
- Shared package ctrl_pkg:
  - state enum (12 states, 4-bit encoding)
  - opcode constants
  - funct constants
  - aluControl codes
  - aluOp enum (add/sub/funct)
- One natural sub-module: alu_decoder (combinational: aluOp + funct -> aluControl). It is reusable by a future single-cycle controller.

Test Plan:
- Reset pulse mid-MEMRD of a lw -> state FETCH immediately, all write strobes 0 during reset; after release, irWrite=1 and dffEnable=1 in the first cycle.
- lw (opcode 100011) -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB. In MEMWB: writeEnable=1, memToReg=1, regDst=0, instrDone=1. 5 cycles total.
- sw (101011) -> memWrite=1 and iOrD=1 in cycle 4 only; writeEnable never asserted.
- R-type, funct 101010 (slt) -> aluControl=111 in EXECUTE. In ALUWB: regDst=1, writeEnable=1.
- beq with zero=1 -> dffEnable=1 and pcSrc=1 in cycle 3. With zero=0 -> dffEnable=0 in cycle 3. Both return to FETCH.
- j (000010) -> jump=1 and dffEnable=1 in cycle 3. Opcode 111111 -> illegalOp=1 in DECODE, next state FETCH, no writes.
